// File: rtl/cnn_pkg.sv
// Shared types and defaults for the convolution window streaming path.
package cnn_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int IMG_SIZE   = 5;
  localparam int MAX_K      = 5;

  typedef logic [DATA_WIDTH-1:0] pixel_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } win_state_e;

  // A kernel is usable when it is non-empty and fits the window register width.
  function automatic logic k_legal(input logic [2:0] k, input int max_k);
    return (k != 3'd0) && (int'(k) <= max_k);
  endfunction

endpackage

// File: rtl/window_origin_ctr.sv
// Window origin walker: row-major r/c stepping by the stride, plus last-window detect.
// Arithmetic is 4 bits wide so origin + stride + kernel (max 12) never wraps.
module window_origin_ctr #(
  parameter int IMG_SIZE = 5
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic       advance,
  input  logic [2:0] k_q,
  input  logic [1:0] s_q,
  output logic [2:0] r,
  output logic [2:0] c,
  output logic       last
);

  localparam logic [3:0] IMG_W = 4'(IMG_SIZE);

  logic [3:0] r_q, r_d, c_q, c_d;
  logic [3:0] r_end, c_end;

  // Next origin: restart at (0,0), or step the column and wrap into the next row band.
  always_comb begin
    r_end = r_q + {2'b00, s_q} + {1'b0, k_q};
    c_end = c_q + {2'b00, s_q} + {1'b0, k_q};
    r_d   = r_q;
    c_d   = c_q;
    if (start) begin
      r_d = 4'd0;
      c_d = 4'd0;
    end else if (advance) begin
      if (c_end <= IMG_W) begin
        c_d = c_q + {2'b00, s_q};
      end else begin
        c_d = 4'd0;
        r_d = r_q + {2'b00, s_q};
      end
    end
    last = (r_end > IMG_W) && (c_end > IMG_W);
  end

  // Origin registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_q <= 4'd0;
      c_q <= 4'd0;
    end else begin
      r_q <= r_d;
      c_q <= c_d;
    end
  end

  assign r = r_q[2:0];
  assign c = c_q[2:0];

endmodule

// File: rtl/conv_window_streamer.sv
// Frame-to-window streamer: latches one flattened frame, then presents every k x k
// window (stride 1 or 2) to the MAC array, one per out_valid/out_ready handshake.
//
// state  | meaning
// IDLE   | waiting for a frame; in_ready high
// STREAM | walking window origins; out_valid high until the last window is taken
module conv_window_streamer #(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int IMG_SIZE   = cnn_pkg::IMG_SIZE,
  parameter int MAX_K      = cnn_pkg::MAX_K
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic [2:0]                            k,
  input  logic                                  stride,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [IMG_SIZE*IMG_SIZE*DATA_WIDTH-1:0] in_cols,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [MAX_K*MAX_K*DATA_WIDTH-1:0]     out_patch,
  output logic [MAX_K*MAX_K-1:0]                out_mask,
  output logic [2:0]                            out_row,
  output logic [2:0]                            out_col,
  output logic                                  out_last,
  output logic                                  cfg_err
);

  import cnn_pkg::*;

  localparam int NPIX = IMG_SIZE * IMG_SIZE;

  win_state_e                     state_q, state_d;
  logic                           in_ready_q, in_ready_d;
  logic                           out_valid_q, out_valid_d;
  logic                           cfg_err_q, cfg_err_d;
  logic [2:0]                     k_q, k_d;
  logic [1:0]                     s_q, s_d;
  logic [NPIX*DATA_WIDTH-1:0]     frame_q, frame_d;
  logic                           start, advance, last_w;
  logic [2:0]                     r_cnt, c_cnt;
  int                             pix;

  window_origin_ctr #(.IMG_SIZE(IMG_SIZE)) u_origin (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .advance (advance),
    .k_q     (k_q),
    .s_q     (s_q),
    .r       (r_cnt),
    .c       (c_cnt),
    .last    (last_w)
  );

  // Frame acceptance, config check and stream sequencing.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cfg_err_d   = 1'b0;
    k_d         = k_q;
    s_d         = s_q;
    frame_d     = frame_q;
    start       = 1'b0;
    advance     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (in_valid && in_ready_q) begin
          frame_d = in_cols;
          k_d     = k;
          s_d     = stride ? 2'd2 : 2'd1;
          if (k_legal(k, MAX_K)) begin
            start       = 1'b1;
            state_d     = STREAM;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        in_ready_d = 1'b0;
        if (out_valid_q && out_ready) begin
          advance = 1'b1;
          // in_ready only returns the cycle after the last window, so no frame
          // can be taken in the same cycle as the final handshake.
          if (last_w) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and frame registers; reset discards any frame in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      k_q         <= 3'd0;
      s_q         <= 2'd0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cfg_err_q   <= cfg_err_d;
      k_q         <= k_d;
      s_q         <= s_d;
      frame_q     <= frame_d;
    end
  end

  // Window mux: pick pixel[r+i][c+j] for the active k x k corner, zero elsewhere.
  always_comb begin
    out_patch = '0;
    out_mask  = '0;
    pix       = 0;
    for (int i = 0; i < MAX_K; i++) begin
      for (int j = 0; j < MAX_K; j++) begin
        pix = (int'(r_cnt) + i) * IMG_SIZE + int'(c_cnt) + j;
        if (out_valid_q && (i < int'(k_q)) && (j < int'(k_q))) begin
          out_mask[i*MAX_K+j] = 1'b1;
          if (pix < NPIX) begin
            out_patch[(i*MAX_K+j)*DATA_WIDTH +: DATA_WIDTH] = frame_q[pix*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign cfg_err   = cfg_err_q;
  assign out_row   = r_cnt;
  assign out_col   = c_cnt;
  assign out_last  = out_valid_q & last_w;

endmodule

// File: tb/tb_conv_window_streamer.sv
// Directed bench for conv_window_streamer with a queue-based window model.
module tb_conv_window_streamer;

  localparam int DW = 8;
  localparam int IS = 5;
  localparam int MK = 5;
  localparam int PW = MK*MK*DW;

  logic                  clk = 1'b0;
  logic                  nrst;
  logic [2:0]            k;
  logic                  stride;
  logic                  in_valid;
  logic                  in_ready;
  logic [IS*IS*DW-1:0]   in_cols;
  logic                  out_valid;
  logic                  out_ready;
  logic [PW-1:0]         out_patch;
  logic [MK*MK-1:0]      out_mask;
  logic [2:0]            out_row;
  logic [2:0]            out_col;
  logic                  out_last;
  logic                  cfg_err;

  conv_window_streamer dut (
    .clk       (clk),
    .nrst      (nrst),
    .k         (k),
    .stride    (stride),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cols   (in_cols),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_patch (out_patch),
    .out_mask  (out_mask),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int cur_fr [IS][IS];
  int cur_k;
  int exp_r [$];
  int exp_c [$];
  int seen  [$];
  int last_cnt;
  bit expect_idle;
  bit rnd;
  bit pin1;
  bit pin_mask_on;
  logic [MK*MK-1:0] pin_mask;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // out_ready: always ready, or a coin flip each cycle when rnd is set
  always @(posedge clk) begin
    #1;
    out_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // compare process: every window shown must equal the model's head window
  always @(negedge clk) begin
    if (nrst) begin
      if (expect_idle) begin
        chk("idle_in_ready", PW'(in_ready), PW'(1));
        chk("idle_out_valid", PW'(out_valid), PW'(0));
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        chk("stream_in_ready", PW'(in_ready), PW'(0));
        chk("stream_cfg_err", PW'(cfg_err), PW'(0));
        if (exp_r.size() == 0) begin
          chk("extra_window", PW'(out_valid), PW'(0));
        end else begin
          int r, c;
          logic [PW-1:0] ep;
          logic [MK*MK-1:0] em;
          r  = exp_r[0];
          c  = exp_c[0];
          ep = '0;
          em = '0;
          for (int i = 0; i < MK; i++)
            for (int j = 0; j < MK; j++)
              if (i < cur_k && j < cur_k) begin
                em[i*MK+j] = 1'b1;
                ep[(i*MK+j)*DW +: DW] = DW'(cur_fr[r+i][c+j]);
              end
          chk("row", PW'(out_row), PW'(r));
          chk("col", PW'(out_col), PW'(c));
          chk("last", PW'(out_last), PW'(exp_r.size() == 1));
          chk("mask", PW'(out_mask), PW'(em));
          chk("patch", out_patch, ep);
          if (pin_mask_on) chk("mask_literal", PW'(out_mask), PW'(pin_mask));
          if (pin1 && out_row == 3'd1 && out_col == 3'd2) begin
            int lit [9];
            lit = '{12, 13, 14, 22, 23, 24, 32, 33, 34};
            for (int i = 0; i < 3; i++)
              for (int j = 0; j < 3; j++)
                chk("pin_w12", PW'(out_patch[(i*MK+j)*DW +: DW]), PW'(lit[i*3+j]));
            chk("pin_w12_masked", PW'(out_patch[3*DW +: DW]), PW'(0));
          end
          if (out_ready) begin
            seen.push_back(r*10 + c);
            if (out_last) last_cnt++;
            void'(exp_r.pop_front());
            void'(exp_c.pop_front());
            if (exp_r.size() == 0) expect_idle = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input int kk, input bit st);
    int cnt;
    int s;
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    chk("in_ready_wait", PW'(in_ready), PW'(1));
    seen.delete();
    last_cnt = 0;
    for (int i = 0; i < IS; i++)
      for (int j = 0; j < IS; j++) begin
        cur_fr[i][j] = 10*i + j;
        in_cols[(i*IS+j)*DW +: DW] = DW'(10*i + j);
      end
    k        = 3'(kk);
    stride   = st;
    in_valid = 1'b1;
    s = st ? 2 : 1;
    if (kk >= 1 && kk <= MK) begin
      cur_k = kk;
      for (int r = 0; r + kk <= IS; r += s)
        for (int c = 0; c + kk <= IS; c += s) begin
          exp_r.push_back(r);
          exp_c.push_back(c);
        end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (kk >= 1 && kk <= MK) begin
      chk("latency1_valid", PW'(out_valid), PW'(1));
      chk("latency1_in_ready", PW'(in_ready), PW'(0));
    end else begin
      chk("cfg_err_pulse", PW'(cfg_err), PW'(1));
      chk("cfg_err_no_valid", PW'(out_valid), PW'(0));
      chk("cfg_err_in_ready", PW'(in_ready), PW'(1));
      @(posedge clk); #1;
      chk("cfg_err_one_cycle", PW'(cfg_err), PW'(0));
      chk("cfg_err_still_idle", PW'(out_valid), PW'(0));
    end
  endtask

  task automatic wait_done(input string nm);
    int cnt;
    cnt = 0;
    while ((exp_r.size() != 0 || out_valid) && cnt < 400) begin
      @(posedge clk); #1; cnt++;
    end
    chk({nm, "_drained"}, PW'(exp_r.size()), PW'(0));
    @(posedge clk); #1;
  endtask

  task automatic check_log(input string nm, input int n, input int e [9]);
    chk({nm, "_count"}, PW'(seen.size()), PW'(n));
    chk({nm, "_last_cnt"}, PW'(last_cnt), PW'(1));
    for (int i = 0; i < n && i < seen.size(); i++)
      chk({nm, "_origin"}, PW'(seen[i]), PW'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int full9 [9];
    int quad  [9];
    int one   [9];
    int cnt;
    full9 = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    quad  = '{0, 2, 20, 22, -1, -1, -1, -1, -1};
    one   = '{0, -1, -1, -1, -1, -1, -1, -1, -1};
    nrst = 1'b0; k = 3'd0; stride = 1'b0; in_valid = 1'b0; in_cols = '0;
    out_ready = 1'b1; rnd = 1'b0; pin1 = 1'b0; pin_mask_on = 1'b0; pin_mask = '0;
    expect_idle = 1'b0; cur_k = 0; last_cnt = 0;

    #3;
    chk("rst_in_ready", PW'(in_ready), PW'(0));
    chk("rst_out_valid", PW'(out_valid), PW'(0));
    chk("rst_patch", out_patch, PW'(0));
    chk("rst_mask", PW'(out_mask), PW'(0));
    chk("rst_rowcol", PW'({out_row, out_col, out_last, cfg_err}), PW'(0));
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    #1 chk("rel_in_ready_low", PW'(in_ready), PW'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_high", PW'(in_ready), PW'(1));

    // 1: k=3 stride 1
    pin1 = 1'b1; pin_mask_on = 1'b1; pin_mask = 25'h1CE7;
    send(3, 1'b0);
    wait_done("t1");
    pin1 = 1'b0;
    check_log("t1", 9, full9);

    // 2: k=3 stride 2
    send(3, 1'b1);
    wait_done("t2");
    check_log("t2", 4, quad);

    // 3: k=2 stride 2, then k=5
    pin_mask = 25'h63;
    send(2, 1'b1);
    wait_done("t3a");
    check_log("t3a", 4, quad);
    pin_mask = 25'h1FF_FFFF;
    send(5, 1'b0);
    wait_done("t3b");
    check_log("t3b", 1, one);
    pin_mask_on = 1'b0;

    // 4: random backpressure
    rnd = 1'b1;
    send(3, 1'b0);
    wait_done("t4");
    rnd = 1'b0;
    check_log("t4", 9, full9);

    // 5: illegal kernels
    send(0, 1'b0);
    send(6, 1'b0);

    // 6: reset during the 4th window
    send(3, 1'b0);
    cnt = 0;
    while (exp_r.size() != 6 && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    chk("t6_reached_w4", PW'(exp_r.size()), PW'(6));
    #2 nrst = 1'b0;
    exp_r.delete(); exp_c.delete(); expect_idle = 1'b0;
    #1;
    chk("t6_rst_valid", PW'(out_valid), PW'(0));
    chk("t6_rst_in_ready", PW'(in_ready), PW'(0));
    chk("t6_rst_patch", out_patch, PW'(0));
    chk("t6_rst_misc", PW'({out_mask, out_row, out_col, out_last, cfg_err}), PW'(0));
    @(posedge clk); #3 nrst = 1'b1;
    @(posedge clk); #1;
    chk("t6_in_ready_after", PW'(in_ready), PW'(1));
    send(3, 1'b0);
    chk("t6_restart_origin", PW'({out_row, out_col}), PW'(0));
    wait_done("t6");
    check_log("t6", 9, full9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
